// File: rtl/apb_arbiter_pkg.sv
// Shared types and constants for the two-master APB arbiter.
//   state_t     : arbiter FSM state encoding
//   NUM_MASTERS : number of APB requesters sharing the completer
//   PROT_W      : width of one pprot field
package apb_arbiter_pkg;

  localparam int unsigned NUM_MASTERS = 2;
  localparam int unsigned PROT_W      = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

endpackage

// File: rtl/apb_arbiter_rr_pick.sv
// Combinational two-way round-robin picker.
//   req   : per-master request
//   last  : master served most recently
//   valid : at least one request present
//   sel   : chosen master (the one that was not served last on a tie)
module rr_pick
  import apb_arbiter_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   last,
  output logic                   valid,
  output logic                   sel
);

  always_comb begin
    valid = |req;
    sel   = 1'b0;
    case (req)
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      2'b11:   sel = ~last;
      default: sel = 1'b0;
    endcase
  end

endmodule

// File: rtl/apb_arbiter.sv
// Two-master to one-slave APB arbiter. Round-robin arbitration, replays the
// granted request to the slave with its own setup/access phases, and holds
// off the waiting master through its pready.
//   pclk, preset          : clock, synchronous active-high reset
//   m_p*                  : per-master APB requester ports (slice i = master i)
//   m_prdata              : slave read data broadcast to both masters
//   m_pready, m_pslverr   : per-master completion and error
//   s_p*                  : APB completer port
module apb_arbiter
  import apb_arbiter_pkg::*;
#(
  parameter  int unsigned AWIDTH = 10,
  parameter  int unsigned DSIZE  = 2,
  localparam int unsigned DBYTES = 1 << DSIZE,
  localparam int unsigned DWIDTH = DBYTES * 8
) (
  input  logic                            pclk,
  input  logic                            preset,
  input  logic [NUM_MASTERS-1:0]          m_psel,
  input  logic [NUM_MASTERS-1:0]          m_penable,
  input  logic [NUM_MASTERS*PROT_W-1:0]   m_pprot,
  input  logic [NUM_MASTERS-1:0]          m_pwrite,
  input  logic [NUM_MASTERS*AWIDTH-1:0]   m_paddr,
  input  logic [NUM_MASTERS*DBYTES-1:0]   m_pstrb,
  input  logic [NUM_MASTERS*DWIDTH-1:0]   m_pwdata,
  output logic [DWIDTH-1:0]               m_prdata,
  output logic [NUM_MASTERS-1:0]          m_pready,
  output logic [NUM_MASTERS-1:0]          m_pslverr,
  output logic                            s_psel,
  output logic                            s_penable,
  output logic [PROT_W-1:0]               s_pprot,
  output logic                            s_pwrite,
  output logic [AWIDTH-1:0]               s_paddr,
  output logic [DBYTES-1:0]               s_pstrb,
  output logic [DWIDTH-1:0]               s_pwdata,
  input  logic [DWIDTH-1:0]               s_prdata,
  input  logic                            s_pready,
  input  logic                            s_pslverr
);

  state_t state_q, state_d;
  logic   grant_q, grant_d;
  logic   last_q, last_d;
  logic   s_psel_q, s_psel_d;
  logic   s_penable_q, s_penable_d;

  logic   pick_valid;
  logic   pick_sel;
  logic   other_req;
  logic   done;

  // A request is psel in either phase, so penable carries no extra information.
  logic   unused_penable;
  assign unused_penable = ^m_penable;

  rr_pick u_rr_pick (
    .req   (m_psel),
    .last  (last_q),
    .valid (pick_valid),
    .sel   (pick_sel)
  );

  // Only the non-granted master can start a back-to-back turn; the completing
  // master's psel still belongs to the transfer that is finishing now.
  assign other_req = m_psel[~grant_q];
  assign done      = (state_q == ACCESS) & s_pready;

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_sel;
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (s_pready) begin
          last_d = grant_q;
          if (other_req) begin
            grant_d = ~grant_q;
            state_d = SETUP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    s_psel_d    = (state_d != IDLE);
    s_penable_d = (state_d == ACCESS);
  end

  // State and registered slave handshake.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
      s_psel_q    <= 1'b0;
      s_penable_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      s_psel_q    <= s_psel_d;
      s_penable_q <= s_penable_d;
    end
  end

  assign s_psel    = s_psel_q;
  assign s_penable = s_penable_q;

  // Request fields come straight from the granted master, which holds them
  // stable until it sees pready.
  always_comb begin
    s_pprot  = grant_q ? m_pprot[2*PROT_W-1:PROT_W]   : m_pprot[PROT_W-1:0];
    s_pwrite = grant_q ? m_pwrite[1]                  : m_pwrite[0];
    s_paddr  = grant_q ? m_paddr[2*AWIDTH-1:AWIDTH]   : m_paddr[AWIDTH-1:0];
    s_pstrb  = grant_q ? m_pstrb[2*DBYTES-1:DBYTES]   : m_pstrb[DBYTES-1:0];
    s_pwdata = grant_q ? m_pwdata[2*DWIDTH-1:DWIDTH]  : m_pwdata[DWIDTH-1:0];
  end

  // Completion is steered to the granted master only.
  assign m_pready  = {grant_q & done, ~grant_q & done};
  assign m_pslverr = {grant_q & done & s_pslverr, ~grant_q & done & s_pslverr};
  assign m_prdata  = s_prdata;

endmodule

// File: tb/tb_apb_arbiter.sv
// Self-checking bench for apb_arbiter: behavioural APB slave with
// programmable wait states, two APB master drivers, and a transaction-level
// reference model of round-robin order, completion cycle and memory contents.
module tb_apb_arbiter;

  localparam int AW = 10;
  localparam int DB = 4;
  localparam int DW = 32;

  logic          pclk = 1'b0;
  logic          preset;
  logic [1:0]    m_psel, m_penable, m_pwrite;
  logic [5:0]    m_pprot;
  logic [2*AW-1:0] m_paddr;
  logic [2*DB-1:0] m_pstrb;
  logic [2*DW-1:0] m_pwdata;
  logic [DW-1:0] m_prdata;
  logic [1:0]    m_pready, m_pslverr;
  logic          s_psel, s_penable, s_pwrite;
  logic [2:0]    s_pprot;
  logic [AW-1:0] s_paddr;
  logic [DB-1:0] s_pstrb;
  logic [DW-1:0] s_pwdata, s_prdata;
  logic          s_pready, s_pslverr;

  always #5 pclk = ~pclk;

  // per-master drivers
  logic          psel_r [2];
  logic          penable_r [2];
  logic          pwrite_r [2];
  logic [2:0]    prot_r [2];
  logic [AW-1:0] addr_r [2];
  logic [DB-1:0] strb_r [2];
  logic [DW-1:0] wdata_r [2];

  assign m_psel    = {psel_r[1], psel_r[0]};
  assign m_penable = {penable_r[1], penable_r[0]};
  assign m_pwrite  = {pwrite_r[1], pwrite_r[0]};
  assign m_pprot   = {prot_r[1], prot_r[0]};
  assign m_paddr   = {addr_r[1], addr_r[0]};
  assign m_pstrb   = {strb_r[1], strb_r[0]};
  assign m_pwdata  = {wdata_r[1], wdata_r[0]};

  apb_arbiter dut (
    .pclk      (pclk),
    .preset    (preset),
    .m_psel    (m_psel),
    .m_penable (m_penable),
    .m_pprot   (m_pprot),
    .m_pwrite  (m_pwrite),
    .m_paddr   (m_paddr),
    .m_pstrb   (m_pstrb),
    .m_pwdata  (m_pwdata),
    .m_prdata  (m_prdata),
    .m_pready  (m_pready),
    .m_pslverr (m_pslverr),
    .s_psel    (s_psel),
    .s_penable (s_penable),
    .s_pprot   (s_pprot),
    .s_pwrite  (s_pwrite),
    .s_paddr   (s_paddr),
    .s_pstrb   (s_pstrb),
    .s_pwdata  (s_pwdata),
    .s_prdata  (s_prdata),
    .s_pready  (s_pready),
    .s_pslverr (s_pslverr)
  );

  // behavioural slave
  int unsigned slv_wait = 0;
  logic        slv_err_en = 1'b0;
  int unsigned wcnt = 0;
  logic [31:0] mem [256];

  assign s_pready  = s_psel && s_penable && (wcnt == slv_wait);
  assign s_pslverr = s_pready && slv_err_en;
  assign s_prdata  = mem[s_paddr[9:2]];

  always @(posedge pclk) begin
    if (s_psel && s_penable && !s_pready) wcnt <= wcnt + 1;
    else                                  wcnt <= 0;
    if (s_pready && s_pwrite)
      for (int b = 0; b < 4; b++)
        if (s_pstrb[b]) mem[s_paddr[9:2]][8*b +: 8] = s_pwdata[8*b +: 8];
  end

  // monitors
  typedef struct packed {
    logic [9:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
  } setup_t;

  setup_t      setup_q [$];
  int          pr_cnt [2] = '{0, 0};
  int          err_cnt [2] = '{0, 0};
  int          proto_bad = 0;
  logic        prev_setup = 1'b0;
  logic        prev_wait = 1'b0;
  int unsigned cyc = 0;

  always @(posedge pclk) cyc <= cyc + 1;

  always @(negedge pclk) begin
    for (int i = 0; i < 2; i++) begin
      if (m_pready[i] === 1'b1)  pr_cnt[i]++;
      if (m_pslverr[i] === 1'b1) err_cnt[i]++;
    end
    if (s_psel && !s_penable)
      setup_q.push_back('{s_paddr, s_pwrite, s_pwdata, s_pstrb, s_pprot});
    if (s_penable && !s_psel) proto_bad++;
    if (s_psel && s_penable && !(prev_setup || prev_wait)) proto_bad++;
    prev_setup = s_psel && !s_penable;
    prev_wait  = s_psel && s_penable && !s_pready;
  end

  // reference model state
  logic [31:0] ref_mem [256];
  logic        model_last;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic xfer(input int m, input logic wr, input logic [9:0] a,
                      input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr,
                      output logic [31:0] rd, output logic er,
                      output int unsigned done_cyc, output logic tmo);
    psel_r[m] = 1'b1; penable_r[m] = 1'b0; pwrite_r[m] = wr;
    addr_r[m] = a; wdata_r[m] = wd; strb_r[m] = st; prot_r[m] = pr;
    tmo = 1'b1; rd = '0; er = 1'b0; done_cyc = 0;
    @(posedge pclk); #1;
    penable_r[m] = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (m_pready[m] === 1'b1) begin
        rd = m_prdata; er = m_pslverr[m]; done_cyc = cyc; tmo = 1'b0;
        break;
      end
      @(posedge pclk); #1;
    end
    @(posedge pclk); #1;
    psel_r[m] = 1'b0; penable_r[m] = 1'b0;
  endtask

  task automatic apply_reset();
    for (int i = 0; i < 2; i++) begin
      psel_r[i] = 0; penable_r[i] = 0; pwrite_r[i] = 0; prot_r[i] = 0;
      addr_r[i] = 0; strb_r[i] = 0; wdata_r[i] = 0;
    end
    preset = 1'b1;
    repeat (2) begin @(posedge pclk); #1; end
    preset = 1'b0;
    model_last = 1'b1;
  endtask

  // One round: masters in mask request; master 1 starts d cycles after master 0.
  task automatic do_round(input logic [1:0] mask, input int unsigned d, input int unsigned w,
                          input logic err_en, input logic allow_wr, input string tag);
    logic        wr [2];
    logic [9:0]  a [2];
    logic [31:0] wd [2];
    logic [3:0]  st [2];
    logic [2:0]  pr [2];
    logic [31:0] rd [2];
    logic        er [2];
    int unsigned dc [2];
    logic        tmo [2];
    logic [31:0] exp_rd [2];
    int unsigned exp_dc [2];
    int          order [$];
    int          pr0 [2];
    int          er0 [2];
    int unsigned c0, s1;
    int          first;
    logic [7:0]  idx;

    for (int m = 0; m < 2; m++) begin
      wr[m] = allow_wr ? 1'($urandom_range(0, 1)) : 1'b0;
      a[m]  = {7'($urandom_range(0, 127)), 1'(m), 2'b00};
      wd[m] = $urandom;
      st[m] = 4'($urandom_range(1, 15));
      pr[m] = 3'($urandom);
      rd[m] = '0; er[m] = 0; dc[m] = 0; tmo[m] = 0; exp_rd[m] = '0; exp_dc[m] = 0;
    end
    slv_wait = w; slv_err_en = err_en;
    c0 = cyc;

    // model: service order and completion cycles
    if (mask == 2'b11) begin
      first = (d == 0) ? (model_last ? 0 : 1) : 0;
      order.push_back(first);
      order.push_back(1 - first);
    end else begin
      order.push_back(mask[1] ? 1 : 0);
    end
    exp_dc[order[0]] = c0 + 2 + w;
    if (order.size() == 2) begin
      s1 = c0 + d;
      exp_dc[order[1]] = (s1 <= exp_dc[order[0]]) ? exp_dc[order[0]] + 2 + w : s1 + 2 + w;
    end
    foreach (order[k]) begin
      idx = a[order[k]][9:2];
      exp_rd[order[k]] = ref_mem[idx];
      if (wr[order[k]])
        for (int b = 0; b < 4; b++)
          if (st[order[k]][b]) ref_mem[idx][8*b +: 8] = wd[order[k]][8*b +: 8];
      model_last = 1'(order[k]);
    end

    for (int m = 0; m < 2; m++) begin pr0[m] = pr_cnt[m]; er0[m] = err_cnt[m]; end
    setup_q.delete();

    fork
      begin
        if (mask[0]) xfer(0, wr[0], a[0], wd[0], st[0], pr[0], rd[0], er[0], dc[0], tmo[0]);
      end
      begin
        if (mask[1]) begin
          if (mask[0]) repeat (d) begin @(posedge pclk); #1; end
          xfer(1, wr[1], a[1], wd[1], st[1], pr[1], rd[1], er[1], dc[1], tmo[1]);
        end
      end
    join

    for (int m = 0; m < 2; m++) begin
      n_tests++;
      if ((pr_cnt[m] - pr0[m]) !== int'(mask[m])) begin
        n_fail++; $display("FAIL %s m%0d pready pulses: got %0d expected %0d", tag, m, pr_cnt[m] - pr0[m], mask[m]);
      end
      n_tests++;
      if ((err_cnt[m] - er0[m]) !== int'(mask[m] & err_en)) begin
        n_fail++; $display("FAIL %s m%0d pslverr pulses: got %0d expected %0d", tag, m, err_cnt[m] - er0[m], mask[m] & err_en);
      end
      if (mask[m]) begin
        n_tests++;
        if (tmo[m] !== 1'b0) begin
          n_fail++; $display("FAIL %s m%0d timeout: got no pready expected pready", tag, m);
        end
        n_tests++;
        if (dc[m] !== exp_dc[m]) begin
          n_fail++; $display("FAIL %s m%0d done cycle: got %0d expected %0d", tag, m, dc[m] - c0, exp_dc[m] - c0);
        end
        n_tests++;
        if (er[m] !== err_en) begin
          n_fail++; $display("FAIL %s m%0d pslverr: got %0b expected %0b", tag, m, er[m], err_en);
        end
        if (!wr[m]) begin
          n_tests++;
          if (rd[m] !== exp_rd[m]) begin
            n_fail++; $display("FAIL %s m%0d prdata: got %08h expected %08h", tag, m, rd[m], exp_rd[m]);
          end
        end
      end
    end
    n_tests++;
    if (setup_q.size() !== order.size()) begin
      n_fail++; $display("FAIL %s setup count: got %0d expected %0d", tag, setup_q.size(), order.size());
    end else begin
      foreach (order[k]) begin
        n_tests++;
        if (setup_q[k].addr !== a[order[k]] || setup_q[k].wr !== wr[order[k]] ||
            setup_q[k].prot !== pr[order[k]]) begin
          n_fail++; $display("FAIL %s setup %0d: got addr %03h wr %0b prot %0d expected addr %03h wr %0b prot %0d",
                             tag, k, setup_q[k].addr, setup_q[k].wr, setup_q[k].prot,
                             a[order[k]], wr[order[k]], pr[order[k]]);
        end
        if (wr[order[k]]) begin
          n_tests++;
          if (setup_q[k].wdata !== wd[order[k]] || setup_q[k].strb !== st[order[k]]) begin
            n_fail++; $display("FAIL %s setup %0d wdata/strb: got %08h/%h expected %08h/%h", tag, k,
                               setup_q[k].wdata, setup_q[k].strb, wd[order[k]], st[order[k]]);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++;
    if (s_psel !== 1'b0 || s_penable !== 1'b0 || m_pready !== 2'b00 || m_pslverr !== 2'b00) begin
      n_fail++; $display("FAIL reset outputs: got psel %b penable %b pready %b pslverr %b expected all 0",
                         s_psel, s_penable, m_pready, m_pslverr);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge pclk); #1;
      n_tests++;
      if (s_psel !== 1'b0 || m_pready !== 2'b00) begin
        n_fail++; $display("FAIL idle cycle %0d: got psel %b pready %b expected 0 00", i, s_psel, m_pready);
      end
    end
  endtask

  task automatic test_single_write();
    logic [31:0] rd;
    logic        er, tmo;
    int unsigned dc, c0;
    int          p0, p1;
    slv_wait = 0; slv_err_en = 0;
    setup_q.delete();
    p0 = pr_cnt[0]; p1 = pr_cnt[1];
    c0 = cyc;
    xfer(0, 1'b1, 10'h010, 32'hDEADBEEF, 4'hF, 3'd2, rd, er, dc, tmo);
    ref_mem[4] = 32'hDEADBEEF;
    model_last = 1'b0;
    n_tests++;
    if (tmo !== 1'b0 || dc - c0 !== 2) begin
      n_fail++; $display("FAIL write latency: got cycle %0d (timeout %0b) expected cycle 2", dc - c0, tmo);
    end
    n_tests++;
    if (setup_q.size() !== 1) begin
      n_fail++; $display("FAIL write setup count: got %0d expected 1", setup_q.size());
    end else if (setup_q[0].addr !== 10'h010 || setup_q[0].wdata !== 32'hDEADBEEF ||
                 setup_q[0].strb !== 4'hF || setup_q[0].wr !== 1'b1) begin
      n_fail++; $display("FAIL write setup fields: got %03h %08h %h %b expected 010 deadbeef f 1",
                         setup_q[0].addr, setup_q[0].wdata, setup_q[0].strb, setup_q[0].wr);
    end
    n_tests++;
    if (pr_cnt[0] - p0 !== 1 || pr_cnt[1] - p1 !== 0) begin
      n_fail++; $display("FAIL write pready pulses: got m0 %0d m1 %0d expected 1 0", pr_cnt[0] - p0, pr_cnt[1] - p1);
    end
    xfer(1, 1'b0, 10'h010, 32'h0, 4'h0, 3'd0, rd, er, dc, tmo);
    model_last = 1'b1;
    n_tests++;
    if (tmo !== 1'b0 || rd !== ref_mem[4]) begin
      n_fail++; $display("FAIL readback: got %08h (timeout %0b) expected %08h", rd, tmo, ref_mem[4]);
    end
  endtask

  task automatic test_contended();
    apply_reset();
    for (int r = 0; r < 8; r++) begin
      do_round(2'b11, 0, $urandom_range(0, 2), 1'b0, (r != 0), "contend");
      n_tests++;
      if (setup_q.size() != 2 || setup_q[0].addr[2] !== 1'b0 || setup_q[1].addr[2] !== 1'b1) begin
        n_fail++; $display("FAIL contend round %0d order: got %0d setups first m%0b expected m0 then m1",
                           r, setup_q.size(), (setup_q.size() > 0) ? setup_q[0].addr[2] : 1'bx);
      end
    end
  endtask

  task automatic test_wait_err();
    for (int g = 0; g < 2; g++)
      do_round(2'(1 << g), 0, 3, 1'b1, 1'b1, "wait_err");
  endtask

  task automatic test_random();
    logic [1:0]  mask;
    int unsigned w, d;
    for (int r = 0; r < 24; r++) begin
      mask = 2'($urandom_range(1, 3));
      w    = $urandom_range(0, 3);
      d    = $urandom_range(0, 5 + w);
      do_round(mask, d, w, ($urandom_range(0, 3) == 0), 1'b1, "random");
    end
  endtask

  task automatic test_reset_mid();
    int p0, p1;
    do_round(2'b01, 0, 0, 1'b0, 1'b0, "pre_rst");
    p0 = pr_cnt[0]; p1 = pr_cnt[1];
    slv_wait = 20;
    psel_r[0] = 1'b1; penable_r[0] = 1'b0; pwrite_r[0] = 1'b0; addr_r[0] = 10'h020;
    @(posedge pclk); #1;
    penable_r[0] = 1'b1;
    @(posedge pclk); #1;
    n_tests++;
    if (s_psel !== 1'b1 || s_penable !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid access: got psel %b penable %b expected 1 1", s_psel, s_penable);
    end
    preset = 1'b1;
    @(posedge pclk); #1;
    n_tests++;
    if (s_psel !== 1'b0 || s_penable !== 1'b0 || m_pready !== 2'b00) begin
      n_fail++; $display("FAIL rst_mid abandon: got psel %b penable %b pready %b expected 0 0 00",
                         s_psel, s_penable, m_pready);
    end
    preset = 1'b0;
    psel_r[0] = 1'b0; penable_r[0] = 1'b0;
    model_last = 1'b1;
    repeat (2) begin @(posedge pclk); #1; end
    n_tests++;
    if (pr_cnt[0] - p0 !== 0 || pr_cnt[1] - p1 !== 0) begin
      n_fail++; $display("FAIL rst_mid pready pulses: got %0d %0d expected 0 0", pr_cnt[0] - p0, pr_cnt[1] - p1);
    end
    do_round(2'b11, 0, 0, 1'b0, 1'b1, "post_rst");
    n_tests++;
    if (setup_q.size() == 0 || setup_q[0].addr[2] !== 1'b0) begin
      n_fail++; $display("FAIL post_rst first grant: got %0d setups expected master 0 first", setup_q.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    model_last = 1'b1;
    preset = 1'b1;
    test_reset();
    test_single_write();
    test_contended();
    test_wait_err();
    test_random();
    test_reset_mid();
    n_tests++;
    if (proto_bad !== 0) begin
      n_fail++; $display("FAIL slave protocol: got %0d bad access phases expected 0", proto_bad);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
